// File: rtl/sync_counter_nbit_pkg.sv
// Shared definitions for the parametrised synchronous counter family:
// default geometry, edge-operation encoding and the parameter sanity check.
package sync_counter_nbit_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 16;

    // Operation applied at the next rising edge, already priority-resolved.
    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_RESET = 3'd1,
        OP_LOAD  = 3'd2,
        OP_UP    = 3'd3,
        OP_DOWN  = 3'd4
    } op_e;

    function automatic bit params_ok(input int width, input int modulus, input int tpd);
        bit ok;
        ok = 1'b1;
        if (width < 1) begin
            ok = 1'b0;
        end else if (modulus < 2) begin
            ok = 1'b0;
        end else if (width < 31 && modulus > (1 << width)) begin
            ok = 1'b0;
        end else if (tpd < 0) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sync_counter_nbit_next.sv
// Combinational next-state and terminal-count logic for one modulo-N counter stage.
module sync_counter_nbit_next
    import sync_counter_nbit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_q_inc,
    output logic [WIDTH-1:0] o_q_dec,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic w_in_range;

    // Out-of-range states (left by a load) recover to 0 going up and to MAX going down.
    always_comb begin
        o_q_inc    = '0;
        o_q_dec    = MAX_Q;
        o_tc       = 1'b0;
        w_in_range = ({1'b0, i_q} < MOD_X);

        if (i_q >= MAX_Q) begin
            o_q_inc = '0;
        end else begin
            o_q_inc = i_q + WIDTH'(1);
        end

        if ((i_q == '0) || !w_in_range) begin
            o_q_dec = MAX_Q;
        end else begin
            o_q_dec = i_q - WIDTH'(1);
        end

        if (i_up) begin
            o_tc = (i_q == MAX_Q);
        end else begin
            o_tc = (i_q == '0);
        end
    end

endmodule

// File: rtl/sync_counter_nbit.sv
// Parametrised synchronous up/down modulo-N counter with ep/et enables,
// active-low parallel load and an et-gated ripple carry for cascading.
module sync_counter_nbit
    import sync_counter_nbit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS,
    parameter int TPD     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ep,
    input  logic             et,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             tc
);

    generate
        if (!params_ok(WIDTH, MODULUS, TPD)) begin : g_bad_params
            $error("sync_counter_nbit: MODULUS %0d outside 2..2**%0d", MODULUS, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_inc;
    logic [WIDTH-1:0] w_q_dec;
    logic             w_tc;
    op_e              w_op;

    sync_counter_nbit_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_q     (r_q),
        .i_up    (up),
        .o_q_inc (w_q_inc),
        .o_q_dec (w_q_dec),
        .o_tc    (w_tc)
    );

    // Edge priority: reset, then load, then count, else hold.
    always_comb begin
        w_op = OP_HOLD;
        if (rst) begin
            w_op = OP_RESET;
        end else if (!load) begin
            w_op = OP_LOAD;
        end else if (ep && et) begin
            w_op = up ? OP_UP : OP_DOWN;
        end else begin
            w_op = OP_HOLD;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        case (w_op)
            OP_RESET: r_q <= '0;
            OP_LOAD:  r_q <= d;
            OP_UP:    r_q <= w_q_inc;
            OP_DOWN:  r_q <= w_q_dec;
            OP_HOLD:  r_q <= r_q;
            default:  r_q <= r_q;
        endcase
    end

    // tc and rco stay combinational so a cascade settles within the same cycle.
    assign q   = r_q;
    assign tc  = w_tc;
    assign rco = et & w_tc;

endmodule

// File: tb/tb_sync_counter_nbit.sv
// Scoreboard bench: directed steps push expected results, a negedge monitor compares.
module tb_sync_counter_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the MODULUS=16 (a) and MODULUS=10 (b) single stages.
    logic       rst = 1'b1, load = 1'b1, ep = 1'b0, et = 1'b0, up = 1'b1;
    logic [3:0] d = 4'h0;
    logic [3:0] a_q, b_q;
    logic       a_rco, a_tc, b_rco, b_tc;

    // Stimulus for the two-stage cascade and the WIDTH=8 reference.
    logic       c_rst = 1'b1, c_load = 1'b1, c_ep = 1'b0, c_et = 1'b0;
    logic [7:0] c_d = 8'h00;
    logic [3:0] c0_q, c1_q;
    logic       c0_rco, c0_tc, c1_rco, c1_tc;
    logic [7:0] e_q;
    logic       e_rco, e_tc;

    sync_counter_nbit #(.WIDTH(4), .MODULUS(16), .TPD(0)) dut_a (
        .clk(clk), .rst(rst), .load(load), .ep(ep), .et(et), .up(up), .d(d),
        .q(a_q), .rco(a_rco), .tc(a_tc));

    sync_counter_nbit #(.WIDTH(4), .MODULUS(10), .TPD(0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .ep(ep), .et(et), .up(up), .d(d),
        .q(b_q), .rco(b_rco), .tc(b_tc));

    sync_counter_nbit #(.WIDTH(4), .MODULUS(16), .TPD(0)) dut_c0 (
        .clk(clk), .rst(c_rst), .load(c_load), .ep(c_ep), .et(c_et), .up(1'b1),
        .d(c_d[3:0]), .q(c0_q), .rco(c0_rco), .tc(c0_tc));

    sync_counter_nbit #(.WIDTH(4), .MODULUS(16), .TPD(0)) dut_c1 (
        .clk(clk), .rst(c_rst), .load(c_load), .ep(c_ep), .et(c0_rco), .up(1'b1),
        .d(c_d[7:4]), .q(c1_q), .rco(c1_rco), .tc(c1_tc));

    sync_counter_nbit #(.WIDTH(8), .MODULUS(256), .TPD(0)) dut_e (
        .clk(clk), .rst(c_rst), .load(c_load), .ep(c_ep), .et(c_et), .up(1'b1),
        .d(c_d), .q(e_q), .rco(e_rco), .tc(e_tc));

    typedef struct {
        int          sel;
        logic [19:0] exp;
        string       name;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cnt      = 0;

    function automatic logic [19:0] actual(input int s);
        logic [19:0] v;
        case (s)
            0:       v = {14'h0, a_q, a_rco, a_tc};
            1:       v = {14'h0, b_q, b_rco, b_tc};
            default: v = {1'b0, c1_q, c0_q, c1_rco, e_q, e_rco, e_tc};
        endcase
        return v;
    endfunction

    // Monitor: one expectation is resolved at each falling edge after its rising edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            item_t it;
            logic [19:0] act;
            it  = sb_q.pop_front();
            act = actual(it.sel);
            n_checks++;
            if (act === it.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
    end

    // Single-stage step: apply controls, expect {q, rco, tc} of the selected stage after the edge.
    task automatic step_ab(input int s, input logic r, input logic l, input logic p,
                           input logic t, input logic u, input logic [3:0] dv,
                           input logic [3:0] eq, input logic erco, input logic etc,
                           input string nm);
        item_t it;
        @(negedge clk);
        #1;
        rst = r; load = l; ep = p; et = t; up = u; d = dv;
        it.sel  = s;
        it.exp  = {14'h0, eq, erco, etc};
        it.name = nm;
        sb_q.push_back(it);
    endtask

    // Cascade step: both the 2x4-bit chain and the 8-bit instance must equal the model count.
    task automatic step_c(input logic l, input logic [7:0] dv, input string nm);
        item_t it;
        logic [7:0] m;
        logic       full;
        @(negedge clk);
        #1;
        c_rst = 1'b0; c_load = l; c_ep = 1'b1; c_et = 1'b1; c_d = dv;
        if (!l) cnt = int'(dv);
        else    cnt = (cnt + 1) % 256;
        m    = 8'(cnt);
        full = (m == 8'hFF);
        it.sel  = 2;
        it.exp  = {1'b0, m, full, m, full, full};
        it.name = nm;
        sb_q.push_back(it);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset wins over load; then load and count through the MODULUS=16 wrap.
        step_ab(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, "a_reset");
        step_ab(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1100, 1'b0, 1'b0, "a_load_c");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1101, 1'b0, 1'b0, "a_up_d");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1110, 1'b0, 1'b0, "a_up_e");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, "a_up_f");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "a_wrap");
        // Enables at q=1111.
        step_ab(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, "a_load_f");
        step_ab(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, "a_ep0_1");
        step_ab(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b1, "a_ep0_2");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1, "a_et0");
        step_ab(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1, "a_both0");
        // Priority.
        step_ab(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0, "a_load_3");
        step_ab(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b0000, 1'b0, 1'b0, "a_rst_over_load");
        step_ab(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 1'b0, 1'b0, "a_load_over_cnt");
        // Direction flip: at 0 down-tc appears without a count, then down wraps to 1111.
        step_ab(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "a_reset2");
        step_ab(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, "a_dir_tc");
        step_ab(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, "a_down_wrap");

        // MODULUS=10 up.
        step_ab(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, "b_load_8");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b1001, 1'b1, 1'b1, "b_up_9");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "b_wrap_0");
        step_ab(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1100, 1'b0, 1'b0, "b_load_oor");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "b_oor_up");
        // MODULUS=10 down.
        step_ab(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "b_load_1");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, "b_down_0");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b0, 1'b0, "b_down_wrap");
        step_ab(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, "b_load_f");
        step_ab(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b0, 1'b0, "b_oor_down");

        // Cascade from 0x0E versus the 8-bit instance and the model, over 300 edges.
        step_c(1'b0, 8'h0E, "casc_load");
        for (int i = 0; i < 300; i++) begin
            step_c(1'b1, 8'h00, $sformatf("casc_%0d", i));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
